fp32_to_int32_seq: RTL and testbench

- Sequential FP32 → signed int32 converter, the decode direction of the FP add path: it unpacks sign/exponent/mantissa and denormalises back to fixed point, where the adder normalises and packs.
- Sits downstream of the FP unit to hand integer results to fixed-point logic.
- Uses valid/ready handshakes on both sides.
- Denormalises with a serial one-bit-per-cycle barrel-free shifter under FSM control, truncating toward zero.

---
 rtl/fp32_to_int32_seq.sv | 116 +++++++++++
 tb/tb_fp32_to_int32_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_seq.sv
// rtl/fp32_to_int32_seq.sv - sequential FP32 to signed int32 converter, truncating toward zero
module fp32_to_int32_seq #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [7:0]  EXP_ONE   = 8'd127;
    localparam logic [7:0]  EXP_ALIGN = 8'd150;  // k == 23: mantissa already integer-aligned
    localparam logic [7:0]  EXP_OVF   = 8'd158;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] INT_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0] FP_INT_MIN = 32'hCF00_0000;

    logic [1:0]  state;
    logic [31:0] mag;
    logic [4:0]  cnt;
    logic        dir_left;
    logic        sign;

    logic        in_sign;
    logic [7:0]  in_exp;
    logic [22:0] in_mant;
    logic [7:0]  left_amt;
    logic [7:0]  right_amt;

    always_comb begin
        in_sign   = in_data[31];
        in_exp    = in_data[30:23];
        in_mant   = in_data[22:0];
        left_amt  = in_exp - EXP_ALIGN;
        right_amt = EXP_ALIGN - in_exp;
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mag      <= 32'd0;
            cnt      <= 5'd0;
            dir_left <= 1'b0;
            sign     <= 1'b0;
            out_data <= 32'd0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (in_exp < EXP_ONE) begin
                            out_data <= 32'd0;
                            out_ovf  <= 1'b0;
                            state    <= ST_OUT;
                        end else if (in_exp >= EXP_OVF) begin
                            // -2^31 is the only |x| >= 2^31 that still fits
                            if (in_data == FP_INT_MIN) begin
                                out_data <= INT_MIN;
                                out_ovf  <= 1'b0;
                            end else begin
                                out_data <= (!in_sign && SAT_EN) ? INT_MAX : INT_MIN;
                                out_ovf  <= 1'b1;
                            end
                            state <= ST_OUT;
                        end else begin
                            mag  <= {8'b0, 1'b1, in_mant};
                            sign <= in_sign;
                            if (in_exp >= EXP_ALIGN) begin
                                dir_left <= 1'b1;
                                cnt      <= left_amt[4:0];
                            end else begin
                                dir_left <= 1'b0;
                                cnt      <= right_amt[4:0];
                            end
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cnt != 5'd0) begin
                        mag <= dir_left ? {mag[30:0], 1'b0} : {1'b0, mag[31:1]};
                        cnt <= cnt - 5'd1;
                    end else begin
                        out_data <= sign ? (32'd0 - mag) : mag;
                        out_ovf  <= 1'b0;
                        state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    mag      <= 32'd0;
                    cnt      <= 5'd0;
                    out_data <= 32'd0;
                    out_ovf  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// tb/tb_fp32_to_int32_seq.sv - randomized bench for fp32_to_int32_seq against an arithmetic model
module tb_fp32_to_int32_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        in_ready_s,  out_valid_s,  out_ovf_s;
    logic [31:0] out_data_s;
    logic        in_ready_w,  out_valid_w,  out_ovf_w;
    logic [31:0] out_data_w;

    int n_cmp;
    int n_err;

    fp32_to_int32_seq #(.SAT_EN(1'b1)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_ovf(out_ovf_s)
    );

    fp32_to_int32_seq #(.SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_data(out_data_w), .out_ovf(out_ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Value by plain integer arithmetic on (1.mant) * 2^(e-150); latency is edges after the accept edge.
    task automatic ref_conv(input logic [31:0] x, input bit sat,
                            output logic [31:0] val, output logic ovf, output int lat);
        int     e, k;
        longint m;
        e = int'(x[30:23]);
        k = e - 127;
        if (e < 127) begin
            val = 32'd0; ovf = 1'b0; lat = 0;
        end else if (k >= 31) begin
            lat = 0;
            if (x == 32'hCF00_0000) begin
                val = 32'h8000_0000; ovf = 1'b0;
            end else begin
                ovf = 1'b1;
                val = (!x[31] && sat) ? 32'h7FFF_FFFF : 32'h8000_0000;
            end
        end else begin
            m = longint'(32'h0080_0000 | {9'b0, x[22:0]});
            if (k >= 23) m = m * (longint'(1) << (k - 23));
            else         m = m / (longint'(1) << (23 - k));
            if (x[31]) m = -m;
            val = m[31:0];
            ovf = 1'b0;
            lat = ((k >= 23) ? (k - 23) : (23 - k)) + 1;
        end
    endtask

    task automatic convert(input logic [31:0] x, input int hold);
        logic [31:0] v_s, v_w;
        logic        o_s, o_w;
        int          lat_exp, lat_w, lat;
        ref_conv(x, 1'b1, v_s, o_s, lat_exp);
        ref_conv(x, 1'b0, v_w, o_w, lat_w);
        @(negedge clk);
        check($sformatf("in_ready idle %08h", x), {31'b0, in_ready_s & in_ready_w}, 32'd1);
        in_valid  = 1'b1;
        in_data   = x;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 0;
        while (!out_valid_s && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("latency %08h", x), lat, lat_exp);
        check($sformatf("data sat %08h", x), out_data_s, v_s);
        check($sformatf("ovf sat %08h", x), {31'b0, out_ovf_s}, {31'b0, o_s});
        check($sformatf("data wrap %08h", x), out_data_w, v_w);
        check($sformatf("ovf wrap %08h", x), {31'b0, out_ovf_w}, {31'b0, o_w});
        check($sformatf("valid wrap %08h", x), {31'b0, out_valid_w}, 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk);
            #1;
            check($sformatf("hold data %08h", x), out_data_s, v_s);
            check($sformatf("hold ready/valid %08h", x),
                  {30'b0, in_ready_s, out_valid_s}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("release %08h", x),
              {28'b0, in_ready_s, out_valid_s, in_ready_w, out_valid_w}, 32'b1010);
    endtask

    logic [31:0] fixed_vec [0:12] = '{
        32'h3F80_0000, 32'hC020_0000, 32'h3F00_0000, 32'h4B00_0000, 32'h4EFF_FFFF,
        32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000, 32'h0000_0000, 32'h8000_0001,
        32'hCF00_0001, 32'hFF80_0000, 32'hBF80_0000
    };

    initial begin
        logic [31:0] x;
        logic [7:0]  e;
        int          sel;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", {in_ready_s, out_valid_s, out_ovf_s, out_data_s[28:0]}, 32'h8000_0000);
        check("reset data", out_data_s, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        convert(32'h3F80_0000, 10);
        for (int i = 0; i < 13; i++) convert(fixed_vec[i], i % 3);

        // async reset in the middle of shifting 1.0
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h3F80_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid-shift reset", {30'b0, in_ready_s, out_valid_s}, 32'b10);
        check("mid-shift reset data", out_data_s, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        convert(32'h4228_0000, 1);

        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      e = 8'd0;
            else if (sel == 1) e = 8'd255;
            else               e = 8'($urandom_range(120, 160));
            x = {1'($urandom), e, 23'($urandom)};
            convert(x, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
